// File: rtl/led_pkg.sv
// led_pkg: LED mode encodings and PWM prescaler math shared by LED and debounce logic
package led_pkg;
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_DIM     = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_e;
  function automatic int tick_div(input int clk_freq, input int out_freq, input int bits);
    int d;
    d = clk_freq / (out_freq * (1 << bits));
    return (d < 1) ? 1 : d;
  endfunction
endpackage

// File: rtl/led_pwm_tick.sv
// led_pwm_tick: prescaler and free-running PWM counter with frame_start on wrap to 0
module led_pwm_tick
  import led_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int PWM_FREQ_HZ = 1000,
  parameter int PWM_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                frame_start
);
  localparam int TICK_DIV = tick_div(CLK_FREQ, PWM_FREQ_HZ, PWM_BITS);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  logic [DW-1:0] div_cnt;
  logic          tick;
  assign tick        = div_cnt == DIV_LAST;
  assign frame_start = tick && (&pwm_cnt);
  // divide the clock down to PWM ticks and advance the duty counter on each tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: command-driven LED PWM/blink/breathe output; define LED_BREATHE_EN to build BREATHE mode
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int CLK_FREQ            = 50_000_000,
  parameter int PWM_FREQ_HZ         = 1000,
  parameter int PWM_BITS            = 8,
  parameter int BLINK_FRAMES        = 250,
  parameter int BREATHE_STEP_FRAMES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_mode_i,
  input  logic [PWM_BITS-1:0] cmd_duty_i,
  output logic                led
);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  logic [PWM_BITS-1:0] pwm_cnt, pend_duty, duty_q;
  logic                frame_start, pending, accept, apply, phase, dim_on, breathe_on, led_d;
  logic [BW-1:0]       blink_cnt;
  led_mode_e           pend_mode, applied_mode, mode_q, mode_d;
  led_pwm_tick #(
    .CLK_FREQ   (CLK_FREQ),
    .PWM_FREQ_HZ(PWM_FREQ_HZ),
    .PWM_BITS   (PWM_BITS)
  ) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_cnt    (pwm_cnt),
    .frame_start(frame_start)
  );
  assign cmd_ready_o = !pending;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign apply       = pending && frame_start;
  assign dim_on      = pwm_cnt < duty_q;
`ifdef LED_BREATHE_EN
  localparam int SW = $clog2(BREATHE_STEP_FRAMES + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(BREATHE_STEP_FRAMES - 1);
  logic [PWM_BITS-1:0] ramp;
  logic [SW-1:0]       step_cnt;
  logic                dir_up;
  assign applied_mode = pend_mode;
  assign breathe_on   = pwm_cnt < ramp;
  // triangle ramp that dwells one step at each end before reversing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp     <= '0;
      step_cnt <= '0;
      dir_up   <= 1'b1;
    end else if (apply) begin
      ramp     <= '0;
      step_cnt <= '0;
      dir_up   <= 1'b1;
    end else if (frame_start) begin
      step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
      if (step_cnt == STEP_LAST) begin
        if (dir_up) begin
          ramp   <= (&ramp) ? ramp - 1'b1 : ramp + 1'b1;
          dir_up <= !(&ramp);
        end else begin
          ramp   <= (ramp == '0) ? {{(PWM_BITS-1){1'b0}}, 1'b1} : ramp - 1'b1;
          dir_up <= ramp == '0;
        end
      end
    end
  end
`else
  assign applied_mode = (pend_mode == MODE_BREATHE) ? MODE_OFF : pend_mode;
  assign breathe_on   = 1'b0;
`endif
  // capture an accepted command and hold it until the next frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      pend_mode <= MODE_OFF;
      pend_duty <= '0;
    end else if (accept) begin
      pending   <= 1'b1;
      pend_mode <= led_mode_e'(cmd_mode_i);
      pend_duty <= cmd_duty_i;
    end else if (apply) begin
      pending <= 1'b0;
    end
  end
  // blink phase flips every BLINK_FRAMES frames, restarting high on each apply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (apply) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (frame_start) begin
      blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
      if (blink_cnt == BLINK_LAST) phase <= !phase;
    end
  end
  // mode state, applied duty and registered LED output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_OFF;
      duty_q <= '0;
      led    <= 1'b0;
    end else begin
      mode_q <= mode_d;
      duty_q <= apply ? pend_duty : duty_q;
      led    <= led_d;
    end
  end
  // next mode on frame-boundary apply and per-mode LED compare
  always_comb begin
    mode_d = apply ? applied_mode : mode_q;
    led_d  = (mode_q == MODE_DIM)     ? dim_on :
             (mode_q == MODE_BLINK)   ? (phase && dim_on) :
             (mode_q == MODE_BREATHE) ? breathe_on : 1'b0;
  end
endmodule

// File: doc/led_pwm_driver.md
# led_pwm_driver

Command-driven LED output stage: accepts mode/brightness commands over a valid/ready handshake and drives a single LED with PWM, blink or breathe patterns. It is the output-side counterpart to the debounced button input path: button or control logic issues commands, and this block owns all LED timing. Commands are applied only at PWM frame boundaries, so the LED never glitches.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- PWM_FREQ_HZ, 1000: PWM frame rate in Hz.
- PWM_BITS, 8: duty resolution. One frame = 2^PWM_BITS ticks.
- BLINK_FRAMES, 250: frames per blink half-period.
- BREATHE_STEP_FRAMES, 2: frames per breathe duty step.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  block can accept a command.
- cmd_mode_i  in  2  led_mode_e: OFF=0, DIM=1, BLINK=2, BREATHE=3.
- cmd_duty_i  in  PWM_BITS  brightness level for DIM and BLINK.
- led  out  1  LED drive, active high, registered.

## Operation
- Prescaler: TICK_DIV = max(1, CLK_FREQ/(PWM_FREQ_HZ·2^PWM_BITS)). Integer division, truncated. Emits a one-cycle tick every TICK_DIV cycles.
- pwm_cnt: PWM_BITS wide. Increments on each tick and wraps from all-ones to 0. frame_start is asserted on the tick that produces the wrap to 0.
- Handshake:
  - A command is accepted when cmd_valid_i and cmd_ready_o are both high in the same cycle.
  - Accepted mode and duty are latched into a pending register, and cmd_ready_o drops the next cycle.
  - The pending command is applied at the first frame_start strictly after the accept cycle. cmd_ready_o returns high the cycle after apply.
  - cmd_valid_i while cmd_ready_o is low is ignored; the issuer holds it.
- Applied-state FSM, mode register:
  - OFF: led 0.
  - DIM: led = (pwm_cnt < duty).
  - BLINK: a phase bit toggles every BLINK_FRAMES frames. Phase 1 behaves as DIM; phase 0 drives led 0. On apply, phase = 1 and the frame counter clears.
  - BREATHE: effective duty ramps up by 1 every BREATHE_STEP_FRAMES frames from 0 to all-ones, then down to 0, and repeats. cmd_duty_i is ignored. On apply, ramp = 0 and direction = up.
- Any new command, including the same mode, restarts that mode's phase and ramp counters.
- Boundaries:
  - duty 0 gives led constantly 0.
  - duty all-ones gives led high for 2^PWM_BITS−1 of 2^PWM_BITS ticks.
  - The ramp holds exactly one step at each end before reversing, so there is no skip or double count at 0 or all-ones.
- Reset mid-operation: all state clears immediately and the pending command is discarded.

## Timing
- Reset values: led 0, cmd_ready_o 1, mode OFF, duty 0, all counters 0, blink phase 1, breathe direction up.
- led is registered. It reflects the compare result from the previous cycle's pwm_cnt, so the output lags the counter by one cycle.
- Command latency:
  - Accept to apply: 1 to 2^PWM_BITS·TICK_DIV cycles.
  - Apply to first led change: 1 cycle.
- Accept in the same cycle as frame_start: apply happens at the next frame_start, not the current one.
- Throughput: at most one command per frame.

## Configuration
- LED_BREATHE_EN defined: BREATHE mode and its ramp counters are built.
- LED_BREATHE_EN undefined:
  - No ramp logic is built.
  - Mode 3 is accepted with normal handshake timing but applies as OFF.

## Structure
- Package led_pkg holds:
  - led_mode_e typedef.
  - Mode encodings.
  - A TICK_DIV compute function shared with the debounce logic's tick math.
- Sub-module led_pwm_tick: prescaler plus pwm_cnt, with frame_start output. It is reusable for other PWM outputs.
- The top level holds the handshake, pending register, mode FSM, blink and breathe counters, and the output register.

## Test plan
Bench parameters: CLK_FREQ=2560, PWM_FREQ_HZ=10, PWM_BITS=8 (TICK_DIV=1, frame=256 cycles), BLINK_FRAMES=2, BREATHE_STEP_FRAMES=1.
- Reset, no commands: led 0 and cmd_ready_o 1 for 1000 cycles.
- DIM, duty 64: cmd_ready_o low until the next frame_start. Then led is high for exactly 64 of every 256 cycles. duty 0 gives 0 high cycles; duty 255 gives 255.
- Accept coinciding with frame_start: apply is deferred a full 256 cycles. A second valid during pending is not accepted.
- BLINK, duty 128: 2 frames with a 128-cycle high pulse each, then 2 frames fully low, repeating.
- BREATHE: per-frame high count is 0,1,…,255,254,…,0.
  - Without LED_BREATHE_EN, led stays 0 after apply.
- Assert rst_n low mid-BLINK with a command pending: led 0 and cmd_ready_o 1 immediately. After release, led stays 0 with no stale apply.
